// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register: hold, shift, rotate, load and clear, with serial
// in/out at both ends and a frame counter that pulses done after WIDTH same-direction shifts.
module universal_shift_register #(
  parameter  int WIDTH = 4,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] pout,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CW-1:0]    count,
  output logic             done
);

  logic [WIDTH-1:0] r_q;
  logic             r_sout_r;
  logic             r_sout_l;
  logic [CW-1:0]    r_count;
  logic             r_dir;
  logic             r_done;

  logic [WIDTH-1:0] w_q_nxt;
  logic             w_sout_r_nxt;
  logic             w_sout_l_nxt;
  logic             w_is_shift;
  logic             w_shift_dir;
  logic             w_cnt_clr;
  logic [CW-1:0]    w_count_nxt;
  logic             w_dir_nxt;
  logic             w_done_nxt;

  // Mode decode: next data register and serial-out values.
  always_comb begin
    w_q_nxt      = r_q;
    w_sout_r_nxt = r_sout_r;
    w_sout_l_nxt = r_sout_l;
    w_is_shift   = 1'b0;
    w_shift_dir  = r_dir;
    w_cnt_clr    = 1'b0;
    case (mode)
      3'b001: begin
        w_q_nxt      = {sin_l, r_q[WIDTH-1:1]};
        w_sout_r_nxt = r_q[0];
        w_is_shift   = 1'b1;
        w_shift_dir  = 1'b0;
      end
      3'b010: begin
        w_q_nxt      = {r_q[WIDTH-2:0], sin_r};
        w_sout_l_nxt = r_q[WIDTH-1];
        w_is_shift   = 1'b1;
        w_shift_dir  = 1'b1;
      end
      3'b011: begin
        w_q_nxt      = {r_q[0], r_q[WIDTH-1:1]};
        w_sout_r_nxt = r_q[0];
        w_is_shift   = 1'b1;
        w_shift_dir  = 1'b0;
      end
      3'b100: begin
        w_q_nxt      = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        w_sout_l_nxt = r_q[WIDTH-1];
        w_is_shift   = 1'b1;
        w_shift_dir  = 1'b1;
      end
      3'b101: begin
        w_q_nxt   = pin;
        w_cnt_clr = 1'b1;
      end
      3'b110: begin
        w_q_nxt      = {WIDTH{1'b0}};
        w_sout_r_nxt = 1'b0;
        w_sout_l_nxt = 1'b0;
        w_cnt_clr    = 1'b1;
      end
      default: begin
        w_q_nxt = r_q;
      end
    endcase
  end

  // Frame counter: a direction change restarts the frame at 1, the WIDTH-th shift wraps and flags done.
  always_comb begin
    w_count_nxt = r_count;
    w_dir_nxt   = r_dir;
    w_done_nxt  = 1'b0;
    if (w_is_shift) begin
      if (w_shift_dir != r_dir) begin
        w_count_nxt = CW'(1);
        w_dir_nxt   = w_shift_dir;
      end else if (r_count == CW'(WIDTH - 1)) begin
        w_count_nxt = {CW{1'b0}};
        w_done_nxt  = 1'b1;
      end else begin
        w_count_nxt = r_count + CW'(1);
      end
    end else if (w_cnt_clr) begin
      w_count_nxt = {CW{1'b0}};
    end else begin
      w_count_nxt = r_count;
    end
  end

  // State update; done is a single-cycle pulse and drops even while stalled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_q      <= {WIDTH{1'b0}};
      r_sout_r <= 1'b0;
      r_sout_l <= 1'b0;
      r_count  <= {CW{1'b0}};
      r_dir    <= 1'b0;
      r_done   <= 1'b0;
    end else if (en) begin
      r_q      <= w_q_nxt;
      r_sout_r <= w_sout_r_nxt;
      r_sout_l <= w_sout_l_nxt;
      r_count  <= w_count_nxt;
      r_dir    <= w_dir_nxt;
      r_done   <= w_done_nxt;
    end else begin
      r_done   <= 1'b0;
    end
  end

  assign pout   = r_q;
  assign sout_r = r_sout_r;
  assign sout_l = r_sout_l;
  assign count  = r_count;
  assign done   = r_done;

endmodule

// File: tb/tb_universal_shift_register.sv
// Bench for universal_shift_register: 4-bit and 8-bit instances share stimulus, an arithmetic
// model is compared every cycle, and directed literal checks pin the expected sequences.
module tb_universal_shift_register;

  logic       clk = 1'b0;
  logic       reset, en, sin_l, sin_r;
  logic [2:0] mode;
  logic [3:0] pin4;
  logic [7:0] pin8;

  logic [3:0] pout4; logic sr4, sl4, done4; logic [1:0] cnt4;
  logic [7:0] pout8; logic sr8, sl8, done8; logic [2:0] cnt8;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  typedef struct {int q; int sr; int sl; int cnt; int dir; int done;} st_t;
  st_t m4, m8;

  universal_shift_register #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .sin_l(sin_l), .sin_r(sin_r),
    .pin(pin4), .pout(pout4), .sout_r(sr4), .sout_l(sl4), .count(cnt4), .done(done4));

  universal_shift_register #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .sin_l(sin_l), .sin_r(sin_r),
    .pin(pin8), .pout(pout8), .sout_r(sr8), .sout_l(sl8), .count(cnt8), .done(done8));

  always #5 clk = ~clk;

  // Frame bookkeeping for one shift/rotate in direction d (0 right, 1 left).
  function automatic st_t frame(st_t n, st_t s, int w, int d);
    st_t r = n;
    if (d != s.dir) begin
      r.cnt = 1; r.dir = d;
    end else if (s.cnt == w - 1) begin
      r.cnt = 0; r.done = 1;
    end else begin
      r.cnt = s.cnt + 1;
    end
    return r;
  endfunction

  function automatic st_t nxt(st_t s, int w, logic rst, logic e, logic [2:0] md,
                              logic si_l, logic si_r, int p);
    st_t n = s;
    int mask = (1 << w) - 1;
    int lsb = s.q & 1;
    int msb = (s.q >> (w - 1)) & 1;
    n.done = 0;
    if (!rst) begin
      n.q = 0; n.sr = 0; n.sl = 0; n.cnt = 0; n.dir = 0;
    end else if (e) begin
      case (md)
        3'd1: begin n.sr = lsb; n.q = (s.q >> 1) | (int'(si_l) << (w - 1)); n = frame(n, s, w, 0); end
        3'd2: begin n.sl = msb; n.q = ((s.q << 1) | int'(si_r)) & mask;     n = frame(n, s, w, 1); end
        3'd3: begin n.sr = lsb; n.q = (s.q >> 1) | (lsb << (w - 1));        n = frame(n, s, w, 0); end
        3'd4: begin n.sl = msb; n.q = ((s.q << 1) | msb) & mask;            n = frame(n, s, w, 1); end
        3'd5: begin n.q = p & mask; n.cnt = 0; end
        3'd6: begin n.q = 0; n.sr = 0; n.sl = 0; n.cnt = 0; end
        default: n.q = s.q;
      endcase
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m4 <= nxt(m4, 4, reset, en, mode, sin_l, sin_r, int'(pin4));
    m8 <= nxt(m8, 8, reset, en, mode, sin_l, sin_r, int'(pin8));
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("m4_pout", 32'(pout4), m4.q);   cmp("m4_sout_r", 32'(sr4), m4.sr);
      cmp("m4_sout_l", 32'(sl4), m4.sl);  cmp("m4_count", 32'(cnt4), m4.cnt);
      cmp("m4_done", 32'(done4), m4.done);
      cmp("m8_pout", 32'(pout8), m8.q);   cmp("m8_sout_r", 32'(sr8), m8.sr);
      cmp("m8_sout_l", 32'(sl8), m8.sl);  cmp("m8_count", 32'(cnt8), m8.cnt);
      cmp("m8_done", 32'(done8), m8.done);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int seq[4] = '{1, 0, 1, 1};
    int rot[8] = '{'h4B, 'h96, 'h2D, 'h5A, 'hB4, 'h69, 'hD2, 'hA5};

    reset = 1'b0; en = 1'b1; mode = 3'b001; sin_l = 1'b1; sin_r = 1'b0;
    pin4 = 4'h0; pin8 = 8'h00;
    for (int i = 0; i < 2; i++) begin
      step();
      chk_en = 1'b1;
      cmp("rst_q", 32'(pout4), 32'h0);   cmp("rst_sout_r", 32'(sr4), 32'h0);
      cmp("rst_count", 32'(cnt4), 32'h0); cmp("rst_done", 32'(done4), 32'h0);
    end
    reset = 1'b1;

    // SISO compatibility
    for (int i = 0; i < 4; i++) begin
      sin_l = seq[i][0];
      step();
      if (i < 3) cmp("siso_done_early", 32'(done4), 32'h0);
    end
    cmp("siso_q", 32'(pout4), 32'hD);
    cmp("siso_done", 32'(done4), 32'h1);
    sin_l = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      cmp("siso_sout_r", 32'(sr4), 32'(seq[i]));
      if (i == 0) cmp("siso_done_pulse", 32'(done4), 32'h0);
    end
    cmp("siso_done2", 32'(done4), 32'h1);

    // Parallel load + rotate left on the 8-bit instance
    mode = 3'b101; pin8 = 8'hA5; pin4 = 4'h3;
    step();
    cmp("load8_q", 32'(pout8), 32'hA5);
    cmp("load8_count", 32'(cnt8), 32'h0);
    mode = 3'b100;
    for (int i = 0; i < 8; i++) begin
      step();
      cmp("rotl8_q", 32'(pout8), 32'(rot[i]));
      if (i < 7) cmp("rotl8_done_early", 32'(done8), 32'h0);
    end
    cmp("rotl8_done", 32'(done8), 32'h1);
    cmp("rotl8_count", 32'(cnt8), 32'h0);

    // Shift left with sin_r=1
    mode = 3'b101; pin4 = 4'h0;
    step();
    mode = 3'b010; sin_r = 1'b1;
    for (int i = 0; i < 3; i++) step();
    cmp("shl_q", 32'(pout4), 32'h7);
    cmp("shl_count", 32'(cnt4), 32'h3);
    cmp("shl_sout_l", 32'(sl4), 32'h0);
    cmp("shl_done_early", 32'(done4), 32'h0);
    step();
    cmp("shl_q4", 32'(pout4), 32'hF);
    cmp("shl_done", 32'(done4), 32'h1);

    // Direction change aborts the frame, then load and clear
    mode = 3'b001; sin_l = 1'b0;
    step(); step();
    mode = 3'b010; sin_r = 1'b0;
    step();
    cmp("dir_count", 32'(cnt4), 32'h1);
    cmp("dir_done", 32'(done4), 32'h0);
    mode = 3'b101; pin4 = 4'h9;
    step();
    cmp("abort_count", 32'(cnt4), 32'h0);
    cmp("abort_q", 32'(pout4), 32'h9);
    cmp("load_keeps_sout_r", 32'(sr4), 32'h1);
    mode = 3'b110;
    step();
    cmp("clr_q", 32'(pout4), 32'h0);
    cmp("clr_sout_r", 32'(sr4), 32'h0);
    cmp("clr_sout_l", 32'(sl4), 32'h0);

    // Stall then reset mid-frame
    mode = 3'b001; sin_l = 1'b1;
    for (int i = 0; i < 3; i++) step();
    cmp("stall_q", 32'(pout4), 32'hE);
    cmp("stall_count", 32'(cnt4), 32'h3);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      cmp("stall_q_frozen", 32'(pout4), 32'hE);
      cmp("stall_count_frozen", 32'(cnt4), 32'h3);
      cmp("stall_done", 32'(done4), 32'h0);
    end
    en = 1'b1; reset = 1'b0;
    step();
    cmp("midrst_q", 32'(pout4), 32'h0);
    cmp("midrst_count", 32'(cnt4), 32'h0);
    cmp("midrst_done", 32'(done4), 32'h0);
    cmp("midrst_sout_r", 32'(sr4), 32'h0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      cmp("postrst_done", 32'(done4), (i == 3) ? 32'h1 : 32'h0);
    end

    // Reserved mode holds
    mode = 3'b111;
    step();
    cmp("rsvd_q", 32'(pout4), 32'hF);
    cmp("rsvd_done", 32'(done4), 32'h0);
    cmp("rsvd_count", 32'(cnt4), 32'h0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/universal_shift_register.md
# universal_shift_register

- Parametrised successor to the team's 4-bit SISO shift register: a WIDTH-bit universal shift register.
- Modes: hold, shift right, shift left, rotate right, rotate left, parallel load and clear, with serial in/out at both ends and parallel in/out.
- A shift counter flags each completed WIDTH-bit serial frame, so the block can serve as a serializer or deserializer in serial-link datapaths.

## Interface
- WIDTH, 4, register width in bits; legal range 2..32.
- CW, $clog2(WIDTH), width of the frame counter (derived; do not override).
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (sampled on rising edge of clk).
- en  input  1  clock enable; 0 freezes all state.
- mode  input  3  operation select (see Operation).
- sin_l  input  1  serial input entering at MSB during shift right.
- sin_r  input  1  serial input entering at LSB during shift left.
- pin  input  WIDTH  parallel load data.
- pout  output  WIDTH  register contents q.
- sout_r  output  1  registered copy of bit shifted out of LSB.
- sout_l  output  1  registered copy of bit shifted out of MSB.
- count  output  CW  shifts completed in current frame.
- done  output  1  one-cycle pulse: WIDTH consecutive same-direction shifts/rotates completed.

## Operation
- Reset (reset=0 at an edge): q=0, sout_r=0, sout_l=0, count=0, done=0, dir=0. Reset overrides en and mode.
- en=0: q, sout_r, sout_l, count and dir hold. done is 0.
- With en=1, mode decodes as follows:
  - 000 hold: q holds; count holds; done=0.
  - 001 shift right: q <= {sin_l, q[WIDTH-1:1]}; sout_r <= q[0]; sout_l holds.
  - 010 shift left: q <= {q[WIDTH-2:0], sin_r}; sout_l <= q[WIDTH-1]; sout_r holds.
  - 011 rotate right: q <= {q[0], q[WIDTH-1:1]}; sout_r <= q[0].
  - 100 rotate left: q <= {q[WIDTH-2:0], q[WIDTH-1]}; sout_l <= q[WIDTH-1].
  - 101 parallel load: q <= pin; count <= 0; sout_r and sout_l hold.
  - 110 clear: q <= 0; sout_r <= 0; sout_l <= 0; count <= 0.
  - 111 reserved: behaves exactly as 000.
- Direction tracking:
  - dir is internal: 0 for right (001/011), 1 for left (010/100).
  - Shift and rotate are the same direction class when dir matches.
- Frame counter, on each shift/rotate with en=1:
  - If direction differs from dir: count <= 1, dir updated, done=0. For WIDTH=2 this is still a 1; no done.
  - Else if count == WIDTH-1: count <= 0, done <= 1 for exactly one cycle.
  - Else: count <= count+1.
- The first shift after reset or load/clear uses dir as stored. Reset leaves dir=0, so the first right shift counts without a restart.
- Load/clear do not change dir. A load or clear mid-frame aborts the frame: count=0 and no done.

## Timing
- All outputs are registered and update only on the rising edge of clk.
- pout reflects the new q the same cycle the edge occurs (zero added latency).
- Serial latency, right direction: a bit presented on sin_l before edge k is in q[WIDTH-1] after edge k, and in q[0] after edge k+WIDTH-1. It appears on sout_r after edge k+WIDTH, assuming continuous shift right with en=1.
- Serial latency, left direction: the same applies symmetrically for sin_r to sout_l.
- Parallel-to-serial: after load at edge k, q[0] appears on sout_r after edge k+1 of the first shift right.
- done asserts after the edge completing the WIDTH-th shift and clears on the next edge, regardless of en.
- Mid-frame stall: en=0 stalls the frame without losing count.
- Reset asserted mid-frame: all state clears at that edge; no done is produced.

## Test plan
- Reset: WIDTH=4; drive mode=001, sin_l=1, reset=0 for 2 edges -> q=0000, sout_r=0, count=0, done=0 throughout.
- SISO compatibility: WIDTH=4; shift right sin_l sequence 1,0,1,1 -> q=1101 after 4th edge, done=1 for one cycle; sout_r after edges 5..8 (sin_l=0) = 1,0,1,1.
- Parallel load + rotate: WIDTH=8; load pin=8'hA5, then 8 rotate-lefts -> q sequence 4B,96,2D,5A,B4,69,D2,A5; done pulses after 8th; count returns 0.
- Shift left, WIDTH=4: load 0000; shift left sin_r=1 x3 -> q=0111, count=3, sout_l=0. One more shift -> q=1111, done=1.
- Direction change and abort: WIDTH=4; 2 shift-rights, then 1 shift-left -> count=1, no done. Then load pin=4'h9 -> count=0; clear -> q=0, sout_r=sout_l=0.
- Stall and reset mid-frame: WIDTH=4; 3 shift-rights, en=0 for 5 cycles -> q and count=3 frozen. Then reset=0 for one edge -> all zero, no done; the next 4 shifts produce done only on the 4th.
